sdi_source_sched: RTL and testbench



---
 rtl/sdi_source_sched_if.sv | 44 ++++
 rtl/sdi_source_sched.sv | 192 +++++++++++++++++++
 tb/tb_sdi_source_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdi_source_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdi_source_sched_if                                                      |
// | Bundle between the source scheduler, the SMPTE 274M generator and the    |
// | external pixel FIFO.                                                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sdi_source_sched_if;
  logic        i_start;
  logic        i_src_sel;
  logic        i_clr;
  logic [11:0] PIX_CNT_i;
  logic [10:0] LINE_CNT_i;
  logic        DATA_RQ_i;
  logic [9:0]  i_fifo_Y;
  logic [9:0]  i_fifo_C;
  logic        i_fifo_empty;
  logic [11:0] i_fifo_level;
  logic        o_EN;
  logic        o_fifo_rd;
  logic [9:0]  o_data_Y;
  logic [9:0]  o_data_C;
  logic        o_src_active;
  logic        o_running;
  logic        o_underflow;
  logic [15:0] o_uf_cnt;

  // Scheduler side
  modport master (
    input  i_start, i_src_sel, i_clr, PIX_CNT_i, LINE_CNT_i, DATA_RQ_i,
           i_fifo_Y, i_fifo_C, i_fifo_empty, i_fifo_level,
    output o_EN, o_fifo_rd, o_data_Y, o_data_C, o_src_active, o_running,
           o_underflow, o_uf_cnt
  );

  // Environment side (generator, FIFO, control)
  modport slave (
    output i_start, i_src_sel, i_clr, PIX_CNT_i, LINE_CNT_i, DATA_RQ_i,
           i_fifo_Y, i_fifo_C, i_fifo_empty, i_fifo_level,
    input  o_EN, o_fifo_rd, o_data_Y, o_data_C, o_src_active, o_running,
           o_underflow, o_uf_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sdi_source_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdi_source_sched                                                         |
// | Frame-aligned source scheduler (colour bars / external FIFO) for the     |
// | 1080p30 HD-SDI transmit generator.                                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sdi_source_sched #(
  parameter int ACTIVE_PIX  = 1920,
  parameter int FRAME_LINES = 1125,
  parameter int PREFILL     = 1024,
  parameter int BAR_WIDTH   = 240
) (
  input wire i_CLK_74m25,
  input wire i_RST,
  sdi_source_sched_if.master bus
);

  localparam int         c_LINE_W  = $clog2(FRAME_LINES);
  localparam logic [9:0] c_BLACK_Y = 10'h040;
  localparam logic [9:0] c_BLACK_C = 10'h200;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_enter_run;
  logic        r_en;
  logic        r_src_active;
  logic [11:0] r_idx;
  logic        r_p1_black;
  logic        r_p1_fifo;
  logic [9:0]  r_p1_y;
  logic [9:0]  r_p1_c;
  logic [9:0]  r_data_y;
  logic [9:0]  r_data_c;
  logic        r_underflow;
  logic [15:0] r_uf_cnt;

  logic        w_frame_start;
  logic        w_live;
  logic        w_lvl_ok;
  logic        w_uf;
  logic        w_rd;
  logic [2:0]  w_bar;
  logic [9:0]  w_pat_y;
  logic [9:0]  w_pat_cb;
  logic [9:0]  w_pat_cr;

  assign w_frame_start = (bus.PIX_CNT_i == 12'd0) &&
                         (bus.LINE_CNT_i[c_LINE_W-1:0] == '0);
  assign w_live        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_lvl_ok      = (bus.i_fifo_level >= 12'(PREFILL));
  assign w_uf          = bus.DATA_RQ_i && w_live && r_src_active && bus.i_fifo_empty;
  assign w_rd          = bus.DATA_RQ_i && w_live && r_src_active && !bus.i_fifo_empty && !i_RST;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_CLK_74m25) begin
    if (i_RST) r_state <= S_OFF;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      S_OFF: begin
        if (bus.i_start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!bus.i_start) begin
          w_state_nxt = S_OFF;
        end else if (!bus.i_src_sel || w_lvl_ok) begin
          w_state_nxt = S_RUN;
          w_enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.i_start) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.i_start)        w_state_nxt = S_RUN;
        else if (w_frame_start) w_state_nxt = S_OFF;
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  // Generator enable is sticky: once the raster runs it is never stopped.
  always_ff @(posedge i_CLK_74m25) begin
    if (i_RST) begin
      r_en         <= 1'b0;
      r_src_active <= 1'b0;
    end else begin
      if (w_enter_run) r_en <= 1'b1;
      if (w_enter_run || ((r_state == S_RUN) && w_frame_start))
        r_src_active <= bus.i_src_sel;
    end
  end

  // ---------------------------------------------------------- pixel index
  always_ff @(posedge i_CLK_74m25) begin
    if (i_RST)                                 r_idx <= 12'd0;
    else if (!bus.DATA_RQ_i)                   r_idx <= 12'd0;
    else if (r_idx != 12'(ACTIVE_PIX - 1))     r_idx <= r_idx + 12'd1;
  end

  // ------------------------------------------------------ colour bars
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_idx >= 12'(k * BAR_WIDTH)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_pat_y  = c_BLACK_Y;
    w_pat_cb = c_BLACK_C;
    w_pat_cr = c_BLACK_C;
    case (w_bar)
      3'd0: begin w_pat_y = 10'd721; w_pat_cb = 10'd512; w_pat_cr = 10'd512; end
      3'd1: begin w_pat_y = 10'd674; w_pat_cb = 10'd176; w_pat_cr = 10'd543; end
      3'd2: begin w_pat_y = 10'd581; w_pat_cb = 10'd589; w_pat_cr = 10'd176; end
      3'd3: begin w_pat_y = 10'd534; w_pat_cb = 10'd253; w_pat_cr = 10'd207; end
      3'd4: begin w_pat_y = 10'd251; w_pat_cb = 10'd771; w_pat_cr = 10'd817; end
      3'd5: begin w_pat_y = 10'd204; w_pat_cb = 10'd448; w_pat_cr = 10'd848; end
      3'd6: begin w_pat_y = 10'd111; w_pat_cb = 10'd848; w_pat_cr = 10'd481; end
      default: begin w_pat_y = 10'd64; w_pat_cb = 10'd512; w_pat_cr = 10'd512; end
    endcase
  end

  // --------------------------------------------------------- 2-stage pipe
  // Stage 1 aligns the pattern with the FIFO's one-cycle read latency and
  // carries the black/underflow decision made in the request cycle.
  always_ff @(posedge i_CLK_74m25) begin
    if (i_RST) begin
      r_p1_black <= 1'b1;
      r_p1_fifo  <= 1'b0;
      r_p1_y     <= c_BLACK_Y;
      r_p1_c     <= c_BLACK_C;
      r_data_y   <= c_BLACK_Y;
      r_data_c   <= c_BLACK_C;
    end else begin
      r_p1_black <= !(bus.DATA_RQ_i && w_live) || w_uf;
      r_p1_fifo  <= r_src_active;
      r_p1_y     <= w_pat_y;
      r_p1_c     <= r_idx[0] ? w_pat_cr : w_pat_cb;
      if (r_p1_black) begin
        r_data_y <= c_BLACK_Y;
        r_data_c <= c_BLACK_C;
      end else if (r_p1_fifo) begin
        r_data_y <= bus.i_fifo_Y;
        r_data_c <= bus.i_fifo_C;
      end else begin
        r_data_y <= r_p1_y;
        r_data_c <= r_p1_c;
      end
    end
  end

  // ------------------------------------------------------------- status
  // A simultaneous clear and underflow restarts the count at one.
  always_ff @(posedge i_CLK_74m25) begin
    if (i_RST) begin
      r_underflow <= 1'b0;
      r_uf_cnt    <= 16'd0;
    end else if (w_uf) begin
      r_underflow <= 1'b1;
      if (bus.i_clr)                  r_uf_cnt <= 16'd1;
      else if (r_uf_cnt != 16'hFFFF)  r_uf_cnt <= r_uf_cnt + 16'd1;
    end else if (bus.i_clr) begin
      r_underflow <= 1'b0;
      r_uf_cnt    <= 16'd0;
    end
  end

  assign bus.o_EN         = r_en;
  assign bus.o_fifo_rd    = w_rd;
  assign bus.o_data_Y     = r_data_y;
  assign bus.o_data_C     = r_data_c;
  assign bus.o_src_active = r_src_active;
  assign bus.o_running    = (r_state == S_RUN);
  assign bus.o_underflow  = r_underflow;
  assign bus.o_uf_cnt     = r_uf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdi_source_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdi_source_sched                                                      |
// | Directed scoreboard bench for sdi_source_sched.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sdi_source_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdi_source_sched_if bus();

  sdi_source_sched #(
    .ACTIVE_PIX (1920),
    .FRAME_LINES(1125),
    .PREFILL    (1024),
    .BAR_WIDTH  (240)
  ) dut (
    .i_CLK_74m25(clk),
    .i_RST      (rst),
    .bus        (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int ek      = 0;
  int fk      = 0;
  bit mon_en  = 1'b0;
  bit d1      = 1'b0;
  bit d2      = 1'b0;
  logic [19:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pat_y(input int idx);
    int b;
    b = idx / 240;
    if (b > 7) b = 7;
    case (b)
      0: return 10'd721;
      1: return 10'd674;
      2: return 10'd581;
      3: return 10'd534;
      4: return 10'd251;
      5: return 10'd204;
      6: return 10'd111;
      default: return 10'd64;
    endcase
  endfunction

  function automatic logic [9:0] pat_c(input int idx);
    int b;
    logic [9:0] cb, cr;
    b = idx / 240;
    if (b > 7) b = 7;
    case (b)
      0: begin cb = 10'd512; cr = 10'd512; end
      1: begin cb = 10'd176; cr = 10'd543; end
      2: begin cb = 10'd589; cr = 10'd176; end
      3: begin cb = 10'd253; cr = 10'd207; end
      4: begin cb = 10'd771; cr = 10'd817; end
      5: begin cb = 10'd448; cr = 10'd848; end
      6: begin cb = 10'd848; cr = 10'd481; end
      default: begin cb = 10'd512; cr = 10'd512; end
    endcase
    return (idx % 2 == 1) ? cr : cb;
  endfunction

  // FIFO model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.o_fifo_rd) begin
      bus.i_fifo_Y <= 10'(100 + fk);
      bus.i_fifo_C <= 10'(600 + fk);
      fk <= fk + 1;
    end
  end

  // Request tracker: a slot requested in cycle t is presented in cycle t+2.
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= bus.DATA_RQ_i;
      d2 <= d1;
    end
  end

  always @(negedge clk) begin
    logic [19:0] e;
    if (mon_en) begin
      if (d2) begin
        if (expq.size() == 0) begin
          chk("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("pixel_YC", {12'd0, bus.o_data_Y, bus.o_data_C}, {12'd0, e});
        end
      end else begin
        chk("blank_YC", {12'd0, bus.o_data_Y, bus.o_data_C}, {12'd0, 10'h040, 10'h200});
      end
    end
  end

  // One request slot: drive DATA_RQ, check the read strobe, queue the pixel.
  task automatic slot(input bit rq, input bit erd, input logic [9:0] ey, input logic [9:0] ec);
    bus.DATA_RQ_i = rq;
    #1;
    chk("fifo_rd", {31'd0, bus.o_fifo_rd}, {31'd0, erd});
    if (rq) expq.push_back({ey, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slot(1'b0, 1'b0, 10'h040, 10'h200);
  endtask

  task automatic black_slot();
    slot(1'b1, 1'b0, 10'h040, 10'h200);
  endtask

  task automatic fifo_slot();
    slot(1'b1, 1'b1, 10'(100 + ek), 10'(600 + ek));
    ek++;
  endtask

  task automatic pattern_slots(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, 1'b0, pat_y(i), pat_c(i));
  endtask

  task automatic frame_slot();
    bus.PIX_CNT_i  = 12'd0;
    bus.LINE_CNT_i = 11'd0;
    idle();
    bus.PIX_CNT_i  = 12'd100;
    bus.LINE_CNT_i = 11'd5;
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_src_sel    = 1'b0;
    bus.i_clr        = 1'b0;
    bus.PIX_CNT_i    = 12'd100;
    bus.LINE_CNT_i   = 11'd5;
    bus.DATA_RQ_i    = 1'b1;
    bus.i_fifo_empty = 1'b0;
    bus.i_fifo_level = 12'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_EN",         {31'd0, bus.o_EN},         32'd0);
    chk("rst_fifo_rd",    {31'd0, bus.o_fifo_rd},    32'd0);
    chk("rst_Y",          {22'd0, bus.o_data_Y},     32'h040);
    chk("rst_C",          {22'd0, bus.o_data_C},     32'h200);
    chk("rst_src_active", {31'd0, bus.o_src_active}, 32'd0);
    chk("rst_running",    {31'd0, bus.o_running},    32'd0);
    chk("rst_underflow",  {31'd0, bus.o_underflow},  32'd0);
    chk("rst_uf_cnt",     {16'd0, bus.o_uf_cnt},     32'd0);
    bus.DATA_RQ_i = 1'b0;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Colour bars: one full active line
    bus.i_start = 1'b1;
    idle();
    idle();
    chk("bars_running", {31'd0, bus.o_running},    32'd1);
    chk("bars_EN",      {31'd0, bus.o_EN},         32'd1);
    chk("bars_src",     {31'd0, bus.o_src_active}, 32'd0);
    pattern_slots(1920);
    repeat (3) idle();

    // Stop -> drain to frame end -> off with black output
    bus.i_start = 1'b0;
    idle();
    chk("drain_running", {31'd0, bus.o_running}, 32'd0);
    pattern_slots(3);
    idle();
    frame_slot();
    chk("off_EN", {31'd0, bus.o_EN}, 32'd1);
    black_slot();
    black_slot();
    idle();

    // External source waits for prefill
    bus.i_src_sel    = 1'b1;
    bus.i_fifo_level = 12'd1000;
    bus.i_start      = 1'b1;
    idle();
    black_slot();
    black_slot();
    idle();
    idle();
    chk("arm_wait_running", {31'd0, bus.o_running}, 32'd0);
    bus.i_fifo_level = 12'd1024;
    idle();
    chk("arm_go_running", {31'd0, bus.o_running},    32'd1);
    chk("arm_go_src",     {31'd0, bus.o_src_active}, 32'd1);
    repeat (8) fifo_slot();

    // Underflow masking and sticky status
    bus.i_fifo_empty = 1'b1;
    repeat (3) black_slot();
    bus.i_fifo_empty = 1'b0;
    chk("uf_flag", {31'd0, bus.o_underflow}, 32'd1);
    chk("uf_cnt3", {16'd0, bus.o_uf_cnt},    32'd3);
    fifo_slot();
    fifo_slot();
    bus.i_fifo_empty = 1'b1;
    bus.i_clr        = 1'b1;
    black_slot();
    bus.i_fifo_empty = 1'b0;
    bus.i_clr        = 1'b0;
    chk("uf_clr_race_flag", {31'd0, bus.o_underflow}, 32'd1);
    chk("uf_clr_race_cnt",  {16'd0, bus.o_uf_cnt},    32'd1);
    bus.i_clr = 1'b1;
    idle();
    bus.i_clr = 1'b0;
    chk("uf_clr_flag", {31'd0, bus.o_underflow}, 32'd0);
    chk("uf_clr_cnt",  {16'd0, bus.o_uf_cnt},    32'd0);
    fifo_slot();
    fifo_slot();
    idle();

    // Source change only at frame start
    bus.i_src_sel = 1'b0;
    repeat (3) fifo_slot();
    chk("src_hold", {31'd0, bus.o_src_active}, 32'd1);
    idle();
    frame_slot();
    chk("src_switch", {31'd0, bus.o_src_active}, 32'd0);
    pattern_slots(5);
    idle();

    // Stop mid-frame: live until frame end, then black
    bus.i_start = 1'b0;
    idle();
    chk("stop_running", {31'd0, bus.o_running}, 32'd0);
    pattern_slots(3);
    idle();
    frame_slot();
    black_slot();
    black_slot();
    chk("stop_EN", {31'd0, bus.o_EN}, 32'd1);
    idle();

    // Reset mid-line during FIFO playback
    bus.i_src_sel    = 1'b1;
    bus.i_fifo_level = 12'd1024;
    bus.i_start      = 1'b1;
    idle();
    idle();
    chk("replay_src", {31'd0, bus.o_src_active}, 32'd1);
    repeat (4) fifo_slot();
    bus.DATA_RQ_i = 1'b1;
    bus.i_start   = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    chk("mid_rst_EN",      {31'd0, bus.o_EN},         32'd0);
    chk("mid_rst_running", {31'd0, bus.o_running},    32'd0);
    chk("mid_rst_src",     {31'd0, bus.o_src_active}, 32'd0);
    black_slot();
    black_slot();
    repeat (3) idle();
    chk("scoreboard_drained", expq.size(), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
